pc_sequencer: RTL

//  Multi-cycle instruction sequencer that owns the program counter and drives the

---
 rtl/pc_sequencer.sv | 75 +++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/EXEC/WB sequencer owning the program counter
module pc_sequencer #(
  parameter int PC_WIDTH    = 16,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 clear,
  input  logic                 mem_ready,
  input  logic                 pc_load_en,
  input  logic [PC_WIDTH-1:0]  pc_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_req,
  output logic                 ir_load,
  output logic                 exec_en,
  output logic                 wb_en,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, WB = 3'd3, HALT = 3'd4} state_t;
  state_t st, nxt;
  logic [7:0] tmo_cnt;
  logic single, tmo;
  assign state     = st;
  assign fetch_req = st == FETCH;
  assign exec_en   = st == EXEC;
  assign wb_en     = st == WB;
  assign halted    = st == HALT;
  assign tmo       = st == FETCH && !mem_ready && tmo_cnt == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = halt_req ? HALT : (run || step) ? FETCH : IDLE;
      FETCH:   nxt = mem_ready ? EXEC : tmo ? HALT : FETCH;
      EXEC:    nxt = WB;
      WB:      nxt = halt_req ? HALT : single ? IDLE : run ? FETCH : IDLE;
      HALT:    nxt = (clear && !halt_req) ? IDLE : HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      pc          <= PC_WIDTH'(RESET_PC);
      ir_load     <= 1'b0;
      fault       <= 1'b0;
      single      <= 1'b0;
      tmo_cnt     <= '0;
      instr_count <= '0;
    end else begin
      st      <= nxt;
      ir_load <= st == FETCH && mem_ready;
      tmo_cnt <= (st == FETCH && !mem_ready && !tmo) ? tmo_cnt + 8'd1 : 8'd0;
      if (tmo)
        fault <= 1'b1;
      else if (st == HALT && nxt == IDLE)
        fault <= 1'b0;
      if (st == IDLE && !halt_req && !run && step)
        single <= 1'b1;
      else if (st == WB || st == HALT)
        single <= 1'b0;
      if (st == WB) begin
        pc          <= pc_load_en ? pc_target : pc + PC_WIDTH'(1);
        instr_count <= &instr_count ? instr_count : instr_count + CNT_WIDTH'(1);
      end
    end
  end
endmodule
